// File: rtl/copperv_fetch.sv
// copperv_fetch: instruction fetch stage, single outstanding bus read feeding a small instruction FIFO
module copperv_fetch #(
  parameter int bus_width  = 32,
  parameter int pc_width   = 32,
  parameter int fifo_depth = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_valid,
  input  logic [pc_width-1:0]  pc,
  output logic                 pc_ready,
  input  logic                 flush,
  output logic                 i_raddr_valid,
  input  logic                 i_raddr_ready,
  output logic [bus_width-1:0] i_raddr,
  input  logic                 i_rdata_valid,
  output logic                 i_rdata_ready,
  input  logic [bus_width-1:0] i_rdata,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [bus_width-1:0] inst,
  output logic [pc_width-1:0]  inst_pc
);
  localparam int AW = fifo_depth > 1 ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  logic [1:0]           r_state;
  logic [pc_width-1:0]  r_req_pc;
  logic                 r_drop;
  logic [bus_width-1:0] r_mem_inst [fifo_depth];
  logic [pc_width-1:0]  r_mem_pc   [fifo_depth];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 w_full, w_accept, w_push, w_pop;
  // Outputs come from registered state only; flush may veto a new accept in its own cycle
  assign w_full        = r_count == CW'(fifo_depth);
  assign pc_ready      = rst && r_state == IDLE && !w_full && !flush;
  assign i_raddr_valid = rst && r_state == ADDR;
  assign i_rdata_ready = rst && r_state == WAIT;
  assign inst_valid    = rst && r_count != '0;
  assign i_raddr       = rst ? bus_width'({r_req_pc[pc_width-1:2], 2'b00}) : '0;
  assign inst          = rst ? r_mem_inst[r_rptr] : '0;
  assign inst_pc       = rst ? r_mem_pc[r_rptr] : '0;
  assign w_accept      = pc_valid && pc_ready;
  assign w_push        = i_rdata_ready && i_rdata_valid && !r_drop && !flush;
  assign w_pop         = inst_valid && inst_ready;
  // Request sequencer: one read in flight, a flushed request still completes but its data is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_req_pc <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= r_state == IDLE ? (w_accept ? ADDR : IDLE) :
                  r_state == ADDR ? (i_raddr_ready ? WAIT : ADDR) :
                  (i_rdata_valid ? IDLE : WAIT);
      r_req_pc <= w_accept ? pc : r_req_pc;
      r_drop   <= (r_state == WAIT && i_rdata_valid) ? 1'b0 :
                  (flush && r_state != IDLE) ? 1'b1 : r_drop;
    end
  end
  // FIFO bookkeeping: flush empties it outright and overrides any pop in the same cycle
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_push ? (r_wptr == AW'(fifo_depth - 1) ? '0 : r_wptr + 1'b1) : r_wptr;
      r_rptr  <= w_pop ? (r_rptr == AW'(fifo_depth - 1) ? '0 : r_rptr + 1'b1) : r_rptr;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // FIFO storage, written only with words that survived flush/drop
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= i_rdata;
      r_mem_pc[r_wptr]   <= r_req_pc;
    end
  end
endmodule

// File: tb/tb_copperv_fetch.sv
// tb_copperv_fetch: directed and randomized checks of copperv_fetch against a transaction-level model
module tb_copperv_fetch;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_valid = 1'b0, flush = 1'b0, i_raddr_ready = 1'b0, i_rdata_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] pc = '0, i_rdata = '0;
  logic        pc_ready, i_raddr_valid, i_rdata_ready, inst_valid;
  logic [31:0] i_raddr, inst, inst_pc;
  int n_chk = 0, n_fail = 0;
  int          m_phase = 0;
  bit          m_drop = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] mq_d[$], mq_p[$];

  copperv_fetch #(.bus_width(32), .pc_width(32), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready), .flush(flush),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_pc_ready();
    return m_phase == 0 && mq_d.size() < DEPTH && !flush;
  endfunction

  task automatic settle();
    #1;
    if (!rst) begin
      chk("rst pc_ready", {31'b0, pc_ready}, 0);
      chk("rst raddr_valid", {31'b0, i_raddr_valid}, 0);
      chk("rst rdata_ready", {31'b0, i_rdata_ready}, 0);
      chk("rst inst_valid", {31'b0, inst_valid}, 0);
      chk("rst raddr", i_raddr, 0);
      chk("rst inst", inst, 0);
      chk("rst inst_pc", inst_pc, 0);
    end else begin
      chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_pc_ready()});
      chk("raddr_valid", {31'b0, i_raddr_valid}, {31'b0, m_phase == 1});
      chk("rdata_ready", {31'b0, i_rdata_ready}, {31'b0, m_phase == 2});
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq_d.size() != 0});
      if (m_phase == 1) chk("raddr", i_raddr, m_pc & 32'hFFFF_FFFC);
      if (mq_d.size() != 0) begin
        chk("inst", inst, mq_d[0]);
        chk("inst_pc", inst_pc, mq_p[0]);
      end
    end
  endtask

  task automatic adv();
    bit acc, ahs, dhs, pop;
    if (!rst) begin
      m_phase = 0;
      m_drop = 0;
      mq_d.delete();
      mq_p.delete();
    end else begin
      acc = pc_valid && exp_pc_ready();
      ahs = m_phase == 1 && i_raddr_ready;
      dhs = m_phase == 2 && i_rdata_valid;
      pop = mq_d.size() != 0 && inst_ready;
      if (flush) begin
        mq_d.delete();
        mq_p.delete();
      end else begin
        if (pop) begin
          void'(mq_d.pop_front());
          void'(mq_p.pop_front());
        end
        if (dhs && !m_drop) begin
          mq_d.push_back(i_rdata);
          mq_p.push_back(m_pc);
        end
      end
      if (dhs) m_drop = 0;
      else if (flush && m_phase != 0) m_drop = 1;
      if (acc) begin
        m_phase = 1;
        m_pc = pc;
      end else if (ahs) m_phase = 2;
      else if (dhs) m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic fetch_one(input logic [31:0] p, input logic [31:0] d, input int stall);
    pc_valid = 1; pc = p;
    settle(); chk("accept", {31'b0, pc_ready}, 1); adv();
    pc_valid = 0; i_raddr_ready = 0;
    for (int k = 0; k < stall; k++) begin
      settle();
      chk("stall raddr_valid", {31'b0, i_raddr_valid}, 1);
      chk("stall raddr", i_raddr, p & 32'hFFFF_FFFC);
      adv();
    end
    i_raddr_ready = 1;
    settle(); chk("addr phase", {31'b0, i_raddr_valid}, 1); adv();
    i_rdata_valid = 1; i_rdata = d;
    settle(); chk("data phase", {31'b0, i_rdata_ready}, 1); adv();
    i_rdata_valid = 0;
  endtask

  initial begin
    @(negedge clk);
    settle(); adv();
    settle(); adv();
    rst = 1;
    i_raddr_ready = 1;
    fetch_one(32'h0, 32'h0000_0013, 0);
    inst_ready = 1;
    settle();
    chk("t1 inst_valid", {31'b0, inst_valid}, 1);
    chk("t1 inst", inst, 32'h0000_0013);
    chk("t1 inst_pc", inst_pc, 32'h0);
    chk("t1 pc_ready", {31'b0, pc_ready}, 1);
    adv();
    inst_ready = 0;
    fetch_one(32'h0, 32'hA0A0_0000, 0);
    fetch_one(32'h4, 32'hA0A0_0004, 0);
    pc_valid = 1; pc = 32'h8;
    settle(); chk("t2 full", {31'b0, pc_ready}, 0); adv();
    inst_ready = 1;
    settle(); chk("t2 head0", inst_pc, 32'h0); chk("t2 pop cycle", {31'b0, pc_ready}, 0); adv();
    inst_ready = 0;
    settle(); chk("t2 reopen", {31'b0, pc_ready}, 1); chk("t2 head1", inst_pc, 32'h4); adv();
    pc_valid = 0; i_raddr_ready = 1;
    settle(); chk("t2 raddr", i_raddr, 32'h8); adv();
    i_rdata_valid = 1; i_rdata = 32'hA0A0_0008;
    settle(); adv();
    i_rdata_valid = 0; inst_ready = 1;
    settle(); chk("t2 drain a", inst_pc, 32'h4); adv();
    settle(); chk("t2 drain b", inst_pc, 32'h8); chk("t2 drain b data", inst, 32'hA0A0_0008); adv();
    settle(); chk("t2 empty", {31'b0, inst_valid}, 0); adv();
    fetch_one(32'h10, 32'h1111_0010, 5);
    settle(); adv();
    inst_ready = 0;
    fetch_one(32'h20, 32'h1111_0020, 0);
    pc_valid = 1; pc = 32'h24;
    settle(); adv();
    pc_valid = 0; i_raddr_ready = 1;
    settle(); adv();
    flush = 1;
    settle(); chk("t4 flush pc_ready", {31'b0, pc_ready}, 0); chk("t4 in wait", {31'b0, i_rdata_ready}, 1); adv();
    flush = 0;
    settle(); chk("t4 flushed", {31'b0, inst_valid}, 0); adv();
    i_rdata_valid = 1; i_rdata = 32'hDEAD_BEEF;
    settle(); chk("t4 late consume", {31'b0, i_rdata_ready}, 1); adv();
    i_rdata_valid = 0;
    settle(); chk("t4 dropped", {31'b0, inst_valid}, 0); adv();
    inst_ready = 1;
    fetch_one(32'h100, 32'hCAFE_0100, 0);
    settle(); chk("t4 refetch", inst, 32'hCAFE_0100); chk("t4 refetch pc", inst_pc, 32'h100); adv();
    fetch_one(32'h7, 32'h0000_0777, 0);
    settle(); chk("t5 inst_pc", inst_pc, 32'h7); adv();
    pc_valid = 1; pc = 32'h40; i_raddr_ready = 0;
    settle(); adv();
    pc_valid = 0;
    settle(); chk("t6 addr", {31'b0, i_raddr_valid}, 1); adv();
    rst = 0;
    settle(); adv();
    i_rdata_valid = 1;
    settle(); chk("t6 in reset", {31'b0, i_raddr_valid}, 0); chk("t6 no pc_ready", {31'b0, pc_ready}, 0); adv();
    rst = 1;
    settle(); chk("t6 ignore late", {31'b0, i_rdata_ready}, 0); chk("t6 pc_ready", {31'b0, pc_ready}, 1); adv();
    settle(); chk("t6 no inst", {31'b0, inst_valid}, 0); adv();
    for (int i = 0; i < 4000; i++) begin
      rst           = $urandom_range(199) != 0;
      pc_valid      = $urandom_range(9) < 7;
      pc            = $urandom;
      flush         = $urandom_range(19) == 0;
      i_raddr_ready = $urandom_range(1) != 0;
      i_rdata_valid = $urandom_range(2) != 0;
      i_rdata       = $urandom;
      inst_ready    = $urandom_range(2) == 0;
      settle();
      adv();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
